// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: PDM microphone capture sequencer.
// Divides the system clock down to the mic clock, strobes the deserializer on
// the first system cycle of each mic-clock high phase, and writes each
// completed 16-bit word into the sample RAM.
// Build option: define PDM_CAPTURE_WRAP_EN for circular-buffer capture that
// runs until stop; otherwise the capture is one-shot and ends after NUM_WORDS.
module pdm_capture_ctrl #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned SETTLE_BIT = 1024,
  parameter int unsigned NUM_WORDS  = 4096,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              pdm_clk_o,
  output logic              pdm_lrsel_o,
  output logic              des_shift,
  output logic              des_clear,
  input  logic [15:0]       des_word_i,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_BIT + 1);
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_BIT - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_WORDS - 1);
`ifdef PDM_CAPTURE_WRAP_EN
  localparam logic [CNT_W-1:0]  WORD_MAX = CNT_W'(NUM_WORDS);
`else
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(NUM_WORDS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [3:0]        bit_cnt;
  logic [ADDR_W-1:0] wr_ptr;

  logic running, tick, pdm_rise, pdm_fall, word_end;
  logic keep_run, enter_settle, write_now;

  // Left channel, data valid on the rising mic-clock edge.
  assign pdm_lrsel_o = 1'b0;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    state_d      = state_q;
    running      = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    tick         = running && (div_cnt == DIV_LAST);
    pdm_rise     = tick && !pdm_clk_o;
    pdm_fall     = tick && pdm_clk_o;
    word_end     = (state_q == S_CAPTURE) && des_shift && (bit_cnt == 4'd15);
    keep_run     = 1'b0;
    enter_settle = 1'b0;
    write_now    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !stop) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (stop)                                  state_d = S_DONE;
        else if (pdm_fall && settle_cnt == SET_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (stop) state_d = S_DONE;
`ifndef PDM_CAPTURE_WRAP_EN
        else if (word_end && word_count == WORD_LAST) state_d = S_DONE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    keep_run     = running && ((state_d == S_SETTLE) || (state_d == S_CAPTURE));
    enter_settle = (state_d == S_SETTLE) && (state_q != S_SETTLE);
    write_now    = word_end && !stop;
  end

  // Divider, strobes, counters and RAM write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pdm_clk_o  <= 1'b0;
      des_shift  <= 1'b0;
      des_clear  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      div_cnt    <= '0;
      settle_cnt <= '0;
      bit_cnt    <= '0;
      wr_ptr     <= '0;
    end else begin
      busy      <= (state_d == S_SETTLE) || (state_d == S_CAPTURE);
      done      <= (state_d == S_DONE);
      div_cnt   <= keep_run ? (tick ? '0 : div_cnt + DIV_W'(1)) : '0;
      pdm_clk_o <= keep_run ? (pdm_clk_o ^ tick) : 1'b0;
      des_shift <= pdm_rise && (state_q == S_CAPTURE) && (state_d == S_CAPTURE);
      des_clear <= (state_q == S_SETTLE) && (state_d == S_CAPTURE);
      mem_we    <= 1'b0;

      if (enter_settle) begin
        settle_cnt <= '0;
        bit_cnt    <= '0;
        word_count <= '0;
        wr_ptr     <= '0;
      end else begin
        if ((state_q == S_SETTLE) && pdm_fall) settle_cnt <= settle_cnt + SET_W'(1);
        if ((state_q == S_CAPTURE) && des_shift) bit_cnt <= bit_cnt + 4'd1;
        if (write_now) begin
          mem_we    <= 1'b1;
          mem_addr  <= wr_ptr;
          mem_wdata <= des_word_i;
          wr_ptr    <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ADDR_W'(1);
`ifdef PDM_CAPTURE_WRAP_EN
          if (word_count != WORD_MAX) word_count <= word_count + CNT_W'(1);
`else
          word_count <= word_count + CNT_W'(1);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Testbench for pdm_capture_ctrl: directed sequence with randomized
// deserializer words, checked against an arithmetic timing/data model.
module tb_pdm_capture_ctrl;

  localparam int unsigned CD = 2;
  localparam int unsigned SB = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset, start, stop;
  logic          busy, done, pdm_clk_o, pdm_lrsel_o, des_shift, des_clear;
  logic [15:0]   des_word_i = 16'h0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW:0]   word_count;

  pdm_capture_ctrl #(
    .CLK_DIV(CD), .SETTLE_BIT(SB), .NUM_WORDS(NW), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .busy(busy), .done(done), .pdm_clk_o(pdm_clk_o), .pdm_lrsel_o(pdm_lrsel_o),
    .des_shift(des_shift), .des_clear(des_clear), .des_word_i(des_word_i),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic all_ones = 1'b0;
  logic [15:0] word_log [8192];
  int shift_q[$], clear_q[$], wr_cyc_q[$], wr_addr_q[$], wr_data_q[$];

  // Deserializer word source: a new value every cycle, logged by cycle.
  initial begin
    forever begin
      @(negedge clock);
      des_word_i = all_ones ? 16'hFFFF : 16'($urandom);
      word_log[cyc % 8192] = des_word_i;
    end
  end

  // Event recorder for strobes and RAM writes.
  always @(negedge clock) begin
    if (des_shift) shift_q.push_back(cyc);
    if (des_clear) clear_q.push_back(cyc);
    if (mem_we) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wdata));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pdm_clk"}, 32'(pdm_clk_o), 0);
    chk({tag, ".lrsel"}, 32'(pdm_lrsel_o), 0);
    chk({tag, ".des_shift"}, 32'(des_shift), 0);
    chk({tag, ".des_clear"}, 32'(des_clear), 0);
    chk({tag, ".mem_we"}, 32'(mem_we), 0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 0);
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, ".word_count"}, 32'(word_count), 0);
  endtask

  task automatic start_run(output int s, output int sh0, output int cl0, output int wr0);
    sh0 = shift_q.size();
    cl0 = clear_q.size();
    wr0 = wr_cyc_q.size();
    s = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_shifts(input string tag, input int sh0, input int n);
    logic ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step(1);
      if (shift_q.size() - sh0 >= n) ok = 1'b1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_writes(input string tag, input int wr0, input int n);
    logic ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step(1);
      if (wr_cyc_q.size() - wr0 >= n) ok = 1'b1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  // Model: capture begins SETTLE_BIT full mic periods after the first SETTLE
  // cycle; shift k lands CLK_DIV + 2*CLK_DIV*k cycles after that; each word is
  // written one cycle after its 16th shift with the word present on that shift.
  task automatic check_run(input string tag, input int s, input int sh0, input int cl0,
                           input int wr0, input int n_sh, input int n_wr);
    int e, ws, idx;
    e = s + 1 + 2 * CD * SB;
    chk({tag, ".n_clear"}, 32'(clear_q.size() - cl0), 1);
    chk({tag, ".clear_cyc"}, 32'((clear_q.size() > cl0) ? clear_q[cl0] : -1), 32'(e));
    chk({tag, ".n_shift"}, 32'(shift_q.size() - sh0), 32'(n_sh));
    for (int k = 0; k < n_sh; k++) begin
      idx = sh0 + k;
      chk({tag, ".shift_cyc"}, 32'((idx < shift_q.size()) ? shift_q[idx] : -1),
          32'(e + CD + 2 * CD * k));
    end
    chk({tag, ".n_write"}, 32'(wr_cyc_q.size() - wr0), 32'(n_wr));
    for (int w = 0; w < n_wr; w++) begin
      idx = wr0 + w;
      ws = e + CD + 2 * CD * (16 * w + 15);
      if (idx < wr_cyc_q.size()) begin
        chk({tag, ".wr_cyc"}, 32'(wr_cyc_q[idx]), 32'(ws + 1));
        chk({tag, ".wr_addr"}, 32'(wr_addr_q[idx]), 32'(w % NW));
        chk({tag, ".wr_data"}, 32'(wr_data_q[idx]), 32'(word_log[ws % 8192]));
      end
    end
  endtask

  initial begin
    int s, sh0, cl0, wr0, wr_before;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;

    // Power-on reset.
    step(3);
    chk_zero("por");
    reset = 1'b0;
    step(1);
    chk_zero("idle");

`ifndef PDM_CAPTURE_WRAP_EN
    // Full one-shot capture with all-ones mic data.
    all_ones = 1'b1;
    start_run(s, sh0, cl0, wr0);
    chk("run1.busy", 32'(busy), 1);
    for (int j = 0; j < int'(2 * CD * SB + 8 * CD); j++) begin
      chk("run1.pdm_clk", 32'(pdm_clk_o), 32'((j / CD) % 2));
      step(1);
    end
    begin
      logic ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
        step(1);
        if (done) ok = 1'b1;
      end
      chk("run1.done_timeout", 32'(ok), 1);
    end
    step(20);
    check_run("run1", s, sh0, cl0, wr0, 16 * NW, NW);
    chk("run1.data_ones", 32'(mem_wdata), 32'h0000FFFF);
    chk("run1.word_count", 32'(word_count), 32'(NW));
    chk("run1.done", 32'(done), 1);
    chk("run1.busy_end", 32'(busy), 0);
    chk("run1.pdm_idle", 32'(pdm_clk_o), 0);
    chk("run1.addr_hold", 32'(mem_addr), 32'(NW - 1));
    all_ones = 1'b0;
`else
    // Circular capture: six words then stop.
    start_run(s, sh0, cl0, wr0);
    wait_writes("wrap.timeout", wr0, 6);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(20);
    check_run("wrap", s, sh0, cl0, wr0, 96, 6);
    chk("wrap.word_count", 32'(word_count), 32'(NW));
    chk("wrap.done", 32'(done), 1);
    chk("wrap.busy", 32'(busy), 0);
    chk("wrap.addr_hold", 32'(mem_addr), 1);
`endif

    // Restart from DONE, then stop ten bits into the third word.
    start_run(s, sh0, cl0, wr0);
    chk("restart.word_count", 32'(word_count), 0);
    chk("restart.done", 32'(done), 0);
    chk("restart.busy", 32'(busy), 1);
    wait_shifts("stop.timeout", sh0, 16 * 2 + 10);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(20);
    check_run("stop", s, sh0, cl0, wr0, 16 * 2 + 10, 2);
    chk("stop.word_count", 32'(word_count), 2);
    chk("stop.done", 32'(done), 1);
    chk("stop.busy", 32'(busy), 0);
    chk("stop.pdm_idle", 32'(pdm_clk_o), 0);
    chk("stop.addr_hold", 32'(mem_addr), 1);

    // start and stop together in DONE: nothing happens.
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("done_ss.done", 32'(done), 1);
      chk("done_ss.busy", 32'(busy), 0);
      chk("done_ss.word_count", 32'(word_count), 2);
      step(1);
    end

    // Reset on the cycle of a 16th strobe: the pending write must not appear.
    start_run(s, sh0, cl0, wr0);
    wait_shifts("rst.timeout", sh0, 16);
    wr_before = wr_cyc_q.size();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk_zero("rst_hold");
    end
    reset = 1'b0;
    step(1);
    chk_zero("rst_idle");
    step(4);
    chk("rst.no_write", 32'(wr_cyc_q.size()), 32'(wr_before));

    // start and stop together in IDLE: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("idle_ss.busy", 32'(busy), 0);
      chk("idle_ss.pdm_clk", 32'(pdm_clk_o), 0);
      chk("idle_ss.done", 32'(done), 0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
